// File: rtl/video_timing_pkg.sv
// Shared video timing definitions: default panel geometry, counter width and
// the lock FSM encoding used by the timing detector.
package video_timing_pkg;

    localparam int H_TOTAL_DEF     = 600;
    localparam int H_ACTIVE_DEF    = 480;
    localparam int V_TOTAL_DEF     = 833;
    localparam int V_ACTIVE_DEF    = 800;
    localparam int LOCK_FRAMES_DEF = 2;
    localparam int CNT_W_DEF       = 11;

    typedef logic [1:0] vt_state_t;

    localparam vt_state_t ST_SEARCH = 2'd0;
    localparam vt_state_t ST_VERIFY = 2'd1;
    localparam vt_state_t ST_LOCKED = 2'd2;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers an active-low sync input and pulses on its falling edge.
// Both flops reset high so that the idle level never looks like an edge.
module sync_edge_detect (
    input  logic clk_pixel,
    input  logic rst_n,
    input  logic sig_i,
    output logic fall_o
);

    logic sig_q;
    logic prev_q;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            sig_q  <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            sig_q  <= sig_i;
            prev_q <= sig_q;
        end
    end

    assign fall_o = prev_q & ~sig_q;

endmodule

// File: rtl/video_timing_detector.sv
// Measures incoming hsync/vsync/active geometry, locks onto a stable mode,
// flags deviation from the expected mode and regenerates pixel coordinates.
module video_timing_detector
    import video_timing_pkg::*;
#(
    parameter int H_TOTAL_EXP  = H_TOTAL_DEF,
    parameter int H_ACTIVE_EXP = H_ACTIVE_DEF,
    parameter int V_TOTAL_EXP  = V_TOTAL_DEF,
    parameter int V_ACTIVE_EXP = V_ACTIVE_DEF,
    parameter int LOCK_FRAMES  = LOCK_FRAMES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             clk_pixel,
    input  logic             rst_n,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             active_in,
    output logic [CNT_W-1:0] meas_h_total,
    output logic [CNT_W-1:0] meas_h_active,
    output logic [CNT_W-1:0] meas_v_total,
    output logic [CNT_W-1:0] meas_v_active,
    output logic             locked,
    output logic             mismatch,
    output logic             err,
    output logic             frame_start,
    output logic             active_out,
    output logic [9:0]       pixel_x,
    output logic [9:0]       pixel_y,
    output logic [1:0]       dbg_state
);

    localparam logic [CNT_W-1:0] CMAX = '1;

    function automatic logic [CNT_W-1:0] sinc(input logic [CNT_W-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    logic hedge, vedge;
    logic s_a_q;

    sync_edge_detect u_hs (.clk_pixel(clk_pixel), .rst_n(rst_n), .sig_i(hsync_in), .fall_o(hedge));
    sync_edge_detect u_vs (.clk_pixel(clk_pixel), .rst_n(rst_n), .sig_i(vsync_in), .fall_o(vedge));

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, a_cnt_q, a_cnt_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d, vact_cnt_q, vact_cnt_d;
    logic [CNT_W-1:0] mht_q, mht_d, mha_q, mha_d, mvt_q, mvt_d, mva_q, mva_d;
    logic [CNT_W-1:0] prev_vt_q, prev_vt_d, prev_va_q, prev_va_d;
    logic             la_q, la_d, line_err_q, line_err_d, skip_q, skip_d, sat_q, sat_d;
    logic             have_prev_q, have_prev_d, locked_q, locked_d, err_q, err_d;
    logic             mismatch_q, mismatch_d, act_out_q;
    logic [2:0]       stable_q, stable_d, stable_inc;
    vt_state_t        state_q, state_d;
    logic [9:0]       px_q, px_d, py_q, py_d;

    logic [CNT_W-1:0] h_inc, snap_vt, snap_va, x_val, y_val;
    logic             hedge_bad, lerr_now, snap_match, sat_now, wd_fire;

    always_comb begin
        h_inc      = sinc(h_cnt_q);
        // Until a full line has been measured after acquisition the reference is stale.
        hedge_bad  = hedge && (h_inc != mht_q) && (state_q != ST_SEARCH) && !skip_q;
        lerr_now   = line_err_q | hedge_bad;
        snap_vt    = hedge ? sinc(line_cnt_q) : line_cnt_q;
        snap_va    = (hedge && la_q) ? sinc(vact_cnt_q) : vact_cnt_q;
        snap_match = (snap_vt == prev_vt_q) && (snap_va == prev_va_q);
        sat_now    = (h_cnt_q == CMAX) || (line_cnt_q == CMAX);
        wd_fire    = sat_now && !sat_q;
        stable_inc = stable_q + 3'd1;
        x_val      = hedge ? '0 : a_cnt_q;
        y_val      = vedge ? '0 : snap_va;

        h_cnt_d     = hedge ? '0 : h_inc;
        a_cnt_d     = a_cnt_q;
        la_d        = hedge ? s_a_q : (la_q | s_a_q);
        line_cnt_d  = line_cnt_q;
        vact_cnt_d  = vact_cnt_q;
        mht_d       = hedge ? h_inc : mht_q;
        mha_d       = mha_q;
        mvt_d       = vedge ? snap_vt : mvt_q;
        mva_d       = vedge ? snap_va : mva_q;
        line_err_d  = vedge ? 1'b0 : lerr_now;
        skip_d      = skip_q;
        sat_d       = sat_now;
        state_d     = state_q;
        stable_d    = stable_q;
        have_prev_d = have_prev_q;
        prev_vt_d   = prev_vt_q;
        prev_va_d   = prev_va_q;
        locked_d    = locked_q;
        err_d       = 1'b0;
        px_d        = px_q;
        py_d        = py_q;

        if (hedge) begin
            a_cnt_d = {{(CNT_W-1){1'b0}}, s_a_q};
            if (a_cnt_q != '0) mha_d = a_cnt_q;
        end else if (s_a_q) begin
            a_cnt_d = sinc(a_cnt_q);
        end

        if (vedge) begin
            line_cnt_d = '0;
            vact_cnt_d = '0;
        end else if (hedge) begin
            line_cnt_d = sinc(line_cnt_q);
            if (la_q) vact_cnt_d = sinc(vact_cnt_q);
        end

        if (vedge && state_q == ST_SEARCH) skip_d = 1'b1;
        else if (hedge)                    skip_d = 1'b0;

        if (vedge) begin
            case (state_q)
                ST_SEARCH: begin
                    state_d     = ST_VERIFY;
                    stable_d    = '0;
                    have_prev_d = 1'b0;
                end
                ST_VERIFY: begin
                    if (!have_prev_q) begin
                        prev_vt_d   = snap_vt;
                        prev_va_d   = snap_va;
                        have_prev_d = 1'b1;
                        stable_d    = '0;
                    end else if (snap_match && !lerr_now) begin
                        stable_d = stable_inc;
                        if (int'(stable_inc) >= LOCK_FRAMES) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        stable_d  = '0;
                        prev_vt_d = snap_vt;
                        prev_va_d = snap_va;
                    end
                end
                ST_LOCKED: begin
                    if (!snap_match || lerr_now) begin
                        state_d   = ST_VERIFY;
                        stable_d  = '0;
                        locked_d  = 1'b0;
                        err_d     = 1'b1;
                        prev_vt_d = snap_vt;
                        prev_va_d = snap_va;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end

        // Watchdog fires once on entering saturation and wins over the frame logic.
        if (wd_fire) begin
            state_d     = ST_SEARCH;
            stable_d    = '0;
            have_prev_d = 1'b0;
            locked_d    = 1'b0;
            err_d       = 1'b1;
        end

        mismatch_d = locked_d && ((mht_d != CNT_W'(H_TOTAL_EXP)) || (mha_d != CNT_W'(H_ACTIVE_EXP)) ||
                                  (mvt_d != CNT_W'(V_TOTAL_EXP)) || (mva_d != CNT_W'(V_ACTIVE_EXP)));

        if (s_a_q) begin
            px_d = x_val[9:0];
            py_d = y_val[9:0];
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            s_a_q <= 1'b0;       h_cnt_q <= '0;       a_cnt_q <= '0;
            line_cnt_q <= '0;    vact_cnt_q <= '0;    la_q <= 1'b0;
            mht_q <= '0;         mha_q <= '0;         mvt_q <= '0;      mva_q <= '0;
            prev_vt_q <= '0;     prev_va_q <= '0;     line_err_q <= 1'b0;
            skip_q <= 1'b0;      sat_q <= 1'b0;       state_q <= ST_SEARCH;
            stable_q <= '0;      have_prev_q <= 1'b0; locked_q <= 1'b0;
            err_q <= 1'b0;       mismatch_q <= 1'b0;  act_out_q <= 1'b0;
            px_q <= '0;          py_q <= '0;
        end else begin
            s_a_q <= active_in;  h_cnt_q <= h_cnt_d;  a_cnt_q <= a_cnt_d;
            line_cnt_q <= line_cnt_d; vact_cnt_q <= vact_cnt_d; la_q <= la_d;
            mht_q <= mht_d;      mha_q <= mha_d;      mvt_q <= mvt_d;   mva_q <= mva_d;
            prev_vt_q <= prev_vt_d; prev_va_q <= prev_va_d; line_err_q <= line_err_d;
            skip_q <= skip_d;    sat_q <= sat_d;      state_q <= state_d;
            stable_q <= stable_d; have_prev_q <= have_prev_d; locked_q <= locked_d;
            err_q <= err_d;      mismatch_q <= mismatch_d; act_out_q <= s_a_q;
            px_q <= px_d;        py_q <= py_d;
        end
    end

    assign meas_h_total  = mht_q;
    assign meas_h_active = mha_q;
    assign meas_v_total  = mvt_q;
    assign meas_v_active = mva_q;
    assign locked        = locked_q;
    assign mismatch      = mismatch_q;
    assign err           = err_q;
    assign frame_start   = vedge;
    assign active_out    = act_out_q;
    assign pixel_x       = px_q;
    assign pixel_y       = py_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_video_timing_detector.sv
// Drives a scaled-down video stream into the timing detector and checks
// measurements, lock behaviour and recovered pixel coordinates.
module tb_video_timing_detector;
    import video_timing_pkg::*;

    localparam int HT = 40, HA = 24, VT = 20, VA = 12;
    localparam int HS_W = 4, AX0 = 8, VS_L = 2, CW = 11;
    localparam int BIG = 1 << 30;

    logic clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    logic          rst_n, hsync_in, vsync_in, active_in;
    logic [CW-1:0] meas_h_total, meas_h_active, meas_v_total, meas_v_active;
    logic          locked, mismatch, err, frame_start, active_out;
    logic [9:0]    pixel_x, pixel_y;
    logic [1:0]    dbg_state;

    video_timing_detector #(
        .H_TOTAL_EXP(HT), .H_ACTIVE_EXP(HA), .V_TOTAL_EXP(VT), .V_ACTIVE_EXP(VA),
        .LOCK_FRAMES(2), .CNT_W(CW)
    ) dut (
        .clk_pixel(clk_pixel), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .active_in(active_in), .meas_h_total(meas_h_total), .meas_h_active(meas_h_active),
        .meas_v_total(meas_v_total), .meas_v_active(meas_v_active), .locked(locked),
        .mismatch(mismatch), .err(err), .frame_start(frame_start), .active_out(active_out),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .dbg_state(dbg_state)
    );

    int vectors = 0, miscompares = 0;
    logic [19:0] exp_q[$];
    int fs_cnt = 0, err_cnt = 0, err_fs = 0, cyc = 0, fs_cyc = 0, e0;
    int exp_lock_fs = 4;
    logic a1 = 1'b0, a2 = 1'b0, lk_prev = 1'b0, err_prev = 1'b0, fs_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_cycle(input logic hs, input logic vs, input logic act, input int x, input int y);
        @(posedge clk_pixel);
        #2;
        hsync_in  = hs;
        vsync_in  = vs;
        active_in = act;
        if (act) exp_q.push_back({10'(y), 10'(x)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic drive_frame(input int ht, input int stretch, input int max_cyc);
        int n = 0;
        for (int l = 0; l < VT; l++) begin
            int len = ht + ((l == stretch) ? 1 : 0);
            for (int c = 0; c < len; c++) begin
                if (n == max_cyc) return;
                drive_cycle(!(c < HS_W), !(l < VS_L), (l < VA) && (c >= AX0) && (c < AX0 + HA), c - AX0, l);
                n++;
            end
        end
    endtask

    task automatic check_zero(input string sc);
        check_eq({sc, "_mht"}, meas_h_total, 0);
        check_eq({sc, "_mha"}, meas_h_active, 0);
        check_eq({sc, "_mvt"}, meas_v_total, 0);
        check_eq({sc, "_mva"}, meas_v_active, 0);
        check_eq({sc, "_locked"}, locked, 0);
        check_eq({sc, "_mismatch"}, mismatch, 0);
        check_eq({sc, "_err"}, err, 0);
        check_eq({sc, "_fs"}, frame_start, 0);
        check_eq({sc, "_act"}, active_out, 0);
        check_eq({sc, "_px"}, pixel_x, 0);
        check_eq({sc, "_py"}, pixel_y, 0);
        check_eq({sc, "_state"}, dbg_state, ST_SEARCH);
    endtask

    task automatic check_lock(input string sc, input int mht, input logic mm, input int errs);
        check_eq({sc, "_locked"}, locked, 1);
        check_eq({sc, "_state"}, dbg_state, ST_LOCKED);
        check_eq({sc, "_mht"}, meas_h_total, mht);
        check_eq({sc, "_mha"}, meas_h_active, HA);
        check_eq({sc, "_mvt"}, meas_v_total, VT);
        check_eq({sc, "_mva"}, meas_v_active, VA);
        check_eq({sc, "_mismatch"}, mismatch, mm);
        check_eq({sc, "_errs"}, err_cnt - e0, errs);
        check_eq({sc, "_frames"}, fs_cnt, 5);
    endtask

    // Monitor: pixel scoreboard, latency and pulse-shape checks.
    initial begin
        forever begin
            @(negedge clk_pixel);
            cyc++;
            if (!rst_n) begin
                a1 = 1'b0;
                a2 = 1'b0;
                exp_q.delete();
            end else begin
                check_eq("act_lat", active_out, a2);
                a2 = a1;
                a1 = active_in;
                if (active_out) begin
                    if (exp_q.size() == 0) check_eq("pix_pending", 32'(exp_q.size()), 1);
                    else check_eq("pix_xy", {pixel_y, pixel_x}, exp_q.pop_front());
                end
                if (frame_start) begin
                    fs_cnt++;
                    fs_cyc = cyc;
                    check_eq("fs_width", fs_prev, 0);
                end
                if (locked && !lk_prev) begin
                    check_eq("lock_fs", fs_cnt, exp_lock_fs);
                    check_eq("lock_lat", cyc - fs_cyc, 1);
                end
                if (err) begin
                    err_cnt++;
                    err_fs = fs_cnt;
                    check_eq("err_width", err_prev, 0);
                    check_eq("err_locked", locked, 0);
                end
            end
            lk_prev  = locked;
            err_prev = err;
            fs_prev  = frame_start;
        end
    end

    initial begin
        rst_n = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; active_in = 1'b0;
        repeat (3) @(posedge clk_pixel);
        #3;
        check_zero("rst");
        @(posedge clk_pixel);
        #2 rst_n = 1'b1;

        // Nominal stream: lock on the 4th frame start.
        e0 = err_cnt;
        repeat (5) drive_frame(HT, -1, BIG);
        check_lock("nom", HT, 1'b0, 0);

        // One stretched line: err at the next frame start, relock two frames later.
        fs_cnt = 0; e0 = err_cnt;
        drive_frame(HT, 5, BIG);
        repeat (4) drive_frame(HT, -1, BIG);
        check_lock("stretch", HT, 1'b0, 1);
        check_eq("stretch_err_fs", err_fs, 2);

        // hsync stuck high: watchdog drops to SEARCH once, then the stream relocks.
        e0 = err_cnt;
        idle(2100);
        check_eq("wd_errs", err_cnt - e0, 1);
        check_eq("wd_locked", locked, 0);
        check_eq("wd_state", dbg_state, ST_SEARCH);
        fs_cnt = 0;
        repeat (5) drive_frame(HT, -1, BIG);
        check_lock("wd_relock", HT, 1'b0, 1);

        // Asynchronous reset in the middle of an active line.
        e0 = err_cnt;
        drive_frame(HT, -1, 6 * HT + 15);
        @(posedge clk_pixel);
        #2 rst_n = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1; active_in = 1'b0;
        #1;
        check_zero("midrst");
        repeat (3) @(posedge clk_pixel);
        #2 rst_n = 1'b1;
        fs_cnt = 0;
        repeat (5) drive_frame(HT, -1, BIG);
        check_lock("rst_relock", HT, 1'b0, 0);

        // Line length off the expected mode: locks but flags mismatch.
        fs_cnt = 0; e0 = err_cnt;
        repeat (5) drive_frame(HT + 4, -1, BIG);
        check_lock("ht44", HT + 4, 1'b1, 1);
        check_eq("ht44_err_fs", err_fs, 2);

        idle(5);
        check_eq("pix_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
